// File: rtl/booth_pkg.sv
// Shared types and helpers for the Booth multiplier pipeline.
// booth_algo uses sext() to widen the augend; booth_drain uses the sum type.
package booth_pkg;

    localparam int BOOTH_WIDTH = 8;

    typedef logic [BOOTH_WIDTH+1:0] booth_sum_t;

    function automatic booth_sum_t sext(input logic [BOOTH_WIDTH-1:0] v);
        return {{2{v[BOOTH_WIDTH-1]}}, v};
    endfunction

endpackage

// File: rtl/booth_drain_if.sv
// Issue-credit, final-step input and result output signals of booth_drain.
interface booth_drain_if
    import booth_pkg::*;
#(
    parameter int WIDTH = BOOTH_WIDTH
);
    logic               issue_ready;
    logic               issue_fire;
    logic [WIDTH+1:0]   din_addend;
    logic [WIDTH+1:0]   din_augend;
    logic               din_valid;
    logic [WIDTH+1:0]   dout_data;
    logic               dout_valid;
    logic               dout_ready;
    logic               err_overflow;

    modport slave (
        output issue_ready, dout_data, dout_valid, err_overflow,
        input  issue_fire, din_addend, din_augend, din_valid, dout_ready
    );

    modport master (
        input  issue_ready, dout_data, dout_valid, err_overflow,
        output issue_fire, din_addend, din_augend, din_valid, dout_ready
    );
endinterface

// File: rtl/booth_fifo.sv
// Circular result buffer with occupancy count; DEPTH need not be a power of two.
// A push into a full buffer is accepted only when a pop frees the slot in the same cycle.
module booth_fifo
    import booth_pkg::*;
#(
    parameter int DW    = BOOTH_WIDTH + 2,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop_req,
    output logic [DW-1:0] dout,
    output logic          empty,
    output logic          pop,
    output logic          overflow
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DW-1:0]    mem_q [DEPTH];
    logic [DW-1:0]    mem_d [DEPTH];
    logic             full;
    logic             wr_en;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        pop      = pop_req && !empty;
        wr_en    = push && (!full || pop);
        overflow = push && full && !pop;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ptr_next(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is intentionally not reset; dout is only meaningful while !empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/booth_drain.sv
// Final Booth addition, result buffering and issue-credit return to the chain head.
// The chain cannot stall, so an operand pair is only launched against a reserved result slot.
module booth_drain
    import booth_pkg::*;
#(
    parameter int WIDTH      = BOOTH_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    booth_drain_if.slave  bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [CNT_W-1:0] credits_q, credits_d;
    logic             err_q, err_d;
    logic [WIDTH+1:0] sum;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             fifo_overflow;
    logic             fire_ok;
    logic             fire_bad;

    assign sum = bus.din_augend + bus.din_addend;

    booth_fifo #(
        .DW    (WIDTH + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (bus.din_valid),
        .din      (sum),
        .pop_req  (bus.dout_ready),
        .dout     (bus.dout_data),
        .empty    (fifo_empty),
        .pop      (fifo_pop),
        .overflow (fifo_overflow)
    );

    always_comb begin
        fire_ok   = bus.issue_fire && (credits_q != '0);
        fire_bad  = bus.issue_fire && (credits_q == '0);
        credits_d = credits_q;
        // Saturate so a protocol break upstream cannot wrap the credit count.
        if (fire_ok && !fifo_pop) begin
            credits_d = credits_q - 1'b1;
        end else if (!fire_ok && fifo_pop && (credits_q != CNT_W'(FIFO_DEPTH))) begin
            credits_d = credits_q + 1'b1;
        end
        err_d = err_q || fire_bad || fifo_overflow;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credits_q <= CNT_W'(FIFO_DEPTH);
            err_q     <= 1'b0;
        end else begin
            credits_q <= credits_d;
            err_q     <= err_d;
        end
    end

    assign bus.issue_ready  = (credits_q != '0);
    assign bus.dout_valid   = !fifo_empty;
    assign bus.err_overflow = err_q;

endmodule

// File: tb/tb_booth_drain.sv
// Directed bench for booth_drain: sums, wrap, backpressure, full push/pop, violations, reset.
module tb_booth_drain;
    import booth_pkg::*;

    localparam int W = 8;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   errors   = 0;
    int   inflight = 0;

    booth_drain_if #(.WIDTH(W)) bus ();

    booth_drain #(.WIDTH(W), .FIFO_DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_inv(input string tag);
        chk(tag, 32'(dut.credits_q) + 32'(dut.u_fifo.count_q) + 32'(inflight), 32'(D));
    endtask

    task automatic fire_n(input int n);
        for (int i = 0; i < n; i++) begin
            bus.issue_fire = 1'b1;
            tick();
            inflight++;
        end
        bus.issue_fire = 1'b0;
    endtask

    task automatic push(input logic [9:0] aug, input logic [9:0] add);
        bus.din_valid  = 1'b1;
        bus.din_augend = aug;
        bus.din_addend = add;
        tick();
        bus.din_valid  = 1'b0;
        if (inflight > 0) inflight--;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.issue_fire = 1'b0;
        bus.din_valid  = 1'b0;
        bus.dout_ready = 1'b0;
        tick();
        rst      = 1'b0;
        inflight = 0;
    endtask

    logic [9:0] exp_fill [4];
    logic [9:0] exp_wrap [4];
    logic [9:0] exp_viol [4];

    initial begin
        exp_fill = '{10'h011, 10'h022, 10'h033, 10'h044};
        exp_wrap = '{10'h102, 10'h103, 10'h104, 10'h105};
        exp_viol = '{10'h00A, 10'h00B, 10'h00C, 10'h00D};
        rst            = 1'b1;
        bus.issue_fire = 1'b0;
        bus.din_valid  = 1'b0;
        bus.din_augend = '0;
        bus.din_addend = '0;
        bus.dout_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_dout_valid", 32'(bus.dout_valid), 0);
        chk("rst_issue_ready", 32'(bus.issue_ready), 1);
        chk("rst_err", 32'(bus.err_overflow), 0);
        chk("rst_credits", 32'(dut.credits_q), 4);
        chk("rst_count", 32'(dut.u_fifo.count_q), 0);

        // Single result: -16 + 4 = -12
        fire_n(1);
        chk("single_credits", 32'(dut.credits_q), 3);
        chk_inv("single_inv_a");
        bus.dout_ready = 1'b1;
        push(10'h3F0, 10'h004);
        chk("single_valid", 32'(bus.dout_valid), 1);
        chk("single_data", 32'(bus.dout_data), 32'h3F4);
        chk_inv("single_inv_b");
        tick();
        chk("single_valid_drop", 32'(bus.dout_valid), 0);
        chk("single_credits_back", 32'(dut.credits_q), 4);

        // Modular wrap of the sum
        fire_n(1);
        push(10'h1FF, 10'h001);
        chk("wrap_data", 32'(bus.dout_data), 32'h200);
        chk("wrap_err", 32'(bus.err_overflow), 0);
        tick();
        chk("wrap_drained", 32'(bus.dout_valid), 0);

        // Backpressure fill
        bus.dout_ready = 1'b0;
        fire_n(3);
        chk("fill_ready_3", 32'(bus.issue_ready), 1);
        fire_n(1);
        chk("fill_ready_4", 32'(bus.issue_ready), 0);
        chk_inv("fill_inv_a");
        for (int i = 0; i < 4; i++) begin
            push(10'(16 * (i + 1)), 10'(i + 1));
            chk_inv("fill_inv_push");
        end
        chk("fill_count", 32'(dut.u_fifo.count_q), 4);
        chk("fill_ready_still_low", 32'(bus.issue_ready), 0);
        bus.dout_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("fill_order", 32'(bus.dout_data), 32'(exp_fill[i]));
            tick();
            if (i == 0) chk("fill_ready_after_pop", 32'(bus.issue_ready), 1);
            chk_inv("fill_inv_pop");
        end
        chk("fill_empty", 32'(bus.dout_valid), 0);
        chk("fill_credits", 32'(dut.credits_q), 4);

        // Full with simultaneous push and pop, across pointer wrap
        bus.dout_ready = 1'b0;
        fire_n(4);
        for (int i = 1; i <= 4; i++) push(10'h100, 10'(i));
        chk("full_count", 32'(dut.u_fifo.count_q), 4);
        bus.dout_ready = 1'b1;
        push(10'h100, 10'h005);
        chk("full_pp_count", 32'(dut.u_fifo.count_q), 4);
        chk("full_pp_err", 32'(bus.err_overflow), 0);
        for (int i = 0; i < 4; i++) begin
            chk("full_pp_order", 32'(bus.dout_data), 32'(exp_wrap[i]));
            tick();
        end
        chk("full_pp_empty", 32'(bus.dout_valid), 0);

        // Violations
        do_reset();
        fire_n(4);
        chk("viol_ready", 32'(bus.issue_ready), 0);
        chk("viol_err_pre", 32'(bus.err_overflow), 0);
        bus.issue_fire = 1'b1;
        tick();
        bus.issue_fire = 1'b0;
        chk("viol_credits", 32'(dut.credits_q), 0);
        chk("viol_err", 32'(bus.err_overflow), 1);
        for (int i = 0; i < 4; i++) push(10'h000, 10'(10 + i));
        push(10'h000, 10'h00E);
        chk("viol_count", 32'(dut.u_fifo.count_q), 4);
        chk("viol_err_sticky", 32'(bus.err_overflow), 1);
        bus.dout_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("viol_order", 32'(bus.dout_data), 32'(exp_viol[i]));
            tick();
        end
        chk("viol_dropped", 32'(bus.dout_valid), 0);
        chk("viol_err_end", 32'(bus.err_overflow), 1);

        // Reset mid-stream, with colliding push and fire
        bus.dout_ready = 1'b0;
        do_reset();
        fire_n(3);
        for (int i = 0; i < 3; i++) push(10'h020, 10'(i));
        chk("mid_count", 32'(dut.u_fifo.count_q), 3);
        rst            = 1'b1;
        bus.din_valid  = 1'b1;
        bus.issue_fire = 1'b1;
        tick();
        rst            = 1'b0;
        bus.din_valid  = 1'b0;
        bus.issue_fire = 1'b0;
        inflight       = 0;
        chk("mid_dout_valid", 32'(bus.dout_valid), 0);
        chk("mid_issue_ready", 32'(bus.issue_ready), 1);
        chk("mid_err", 32'(bus.err_overflow), 0);
        chk("mid_credits", 32'(dut.credits_q), 4);
        chk("mid_count_zero", 32'(dut.u_fifo.count_q), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
